// File: rtl/async_fifo.sv
// Dual-clock FIFO: write side on wr_clk_i, read side on rd_clk_i.
// Pointers cross between the two clock domains only as Gray code, through 2-flop synchronizers.
module async_fifo #(
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
) (
    input  logic             wr_clk_i,
    input  logic             rd_clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             wr_en_i,
    output logic             full_o,
    output logic             wr_error_o,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             rd_error_o
);

    localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH:0] wr_ptr, wr_ptr_next, wr_ptr_gray;
    logic [PTR_WIDTH:0] rd_ptr, rd_ptr_next, rd_ptr_gray;
    logic [PTR_WIDTH:0] rd_gray_s1, rd_ptr_gray_sync;
    logic [PTR_WIDTH:0] wr_gray_s1, wr_ptr_gray_sync;
    logic               wr_fire, rd_fire;

    function automatic logic [PTR_WIDTH:0] bin2gray(input logic [PTR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    assign wr_ptr_next = wr_ptr + PTR_ONE;
    assign rd_ptr_next = rd_ptr + PTR_ONE;
    assign wr_fire     = wr_en_i && !full_o;
    assign rd_fire     = rd_en_i && !empty_o;

    // Full when the two pointers differ only in the top two Gray bits (one lap apart)
    assign full_o  = (wr_ptr_gray == {~rd_ptr_gray_sync[PTR_WIDTH:PTR_WIDTH-1],
                                      rd_ptr_gray_sync[PTR_WIDTH-2:0]});
    assign empty_o = (rd_ptr_gray == wr_ptr_gray_sync);

    // The storage array is not reset.
    always_ff @(posedge wr_clk_i) begin
        if (wr_fire)
            mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i;
    end

    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr           <= '0;
            wr_ptr_gray      <= '0;
            wr_error_o       <= 1'b0;
            rd_gray_s1       <= '0;
            rd_ptr_gray_sync <= '0;
        end else begin
            rd_gray_s1       <= rd_ptr_gray;
            rd_ptr_gray_sync <= rd_gray_s1;
            wr_error_o       <= wr_en_i && full_o;
            if (wr_fire) begin
                wr_ptr      <= wr_ptr_next;
                wr_ptr_gray <= bin2gray(wr_ptr_next);
            end
        end
    end

    always_ff @(posedge rd_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr           <= '0;
            rd_ptr_gray      <= '0;
            rdata_o          <= '0;
            rd_error_o       <= 1'b0;
            wr_gray_s1       <= '0;
            wr_ptr_gray_sync <= '0;
        end else begin
            wr_gray_s1       <= wr_ptr_gray;
            wr_ptr_gray_sync <= wr_gray_s1;
            rd_error_o       <= rd_en_i && empty_o;
            if (rd_fire) begin
                rdata_o     <= mem[rd_ptr[PTR_WIDTH-1:0]];
                rd_ptr      <= rd_ptr_next;
                rd_ptr_gray <= bin2gray(rd_ptr_next);
            end
        end
    end

endmodule

// File: tb/tb_async_fifo.sv
// Testbench for async_fifo. Stimulus pushes every word it expects to be stored into a scoreboard
// queue; separate monitors check read data and both error pulses on every clock edge.
module tb_async_fifo;

    logic       wr_clk_i = 1'b0;
    logic       rd_clk_i = 1'b0;
    logic       rst_i    = 1'b1;
    logic [7:0] wdata_i  = '0;
    logic       wr_en_i  = 1'b0;
    logic       rd_en_i  = 1'b0;
    logic       full_o, wr_error_o, empty_o, rd_error_o;
    logic [7:0] rdata_o;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb [$];

    async_fifo #(.DEPTH(16), .WIDTH(8), .PTR_WIDTH(4)) dut (
        .wr_clk_i   (wr_clk_i),
        .rd_clk_i   (rd_clk_i),
        .rst_i      (rst_i),
        .wdata_i    (wdata_i),
        .wr_en_i    (wr_en_i),
        .full_o     (full_o),
        .wr_error_o (wr_error_o),
        .rd_en_i    (rd_en_i),
        .rdata_o    (rdata_o),
        .empty_o    (empty_o),
        .rd_error_o (rd_error_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;
    always #7 rd_clk_i = ~rd_clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-side monitor: data of each accepted read, and the rd_error_o pulse.
    initial begin
        logic       fire, err_exp;
        logic [7:0] exp_data;
        forever begin
            @(posedge rd_clk_i);
            fire    = rd_en_i && !empty_o && !rst_i;
            err_exp = rd_en_i &&  empty_o && !rst_i;
            #1;
            if (fire) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rdata_unexpected: got %0h expected no read data", rdata_o);
                end else begin
                    exp_data = sb.pop_front();
                    check("rdata", 32'(rdata_o), 32'(exp_data));
                end
            end
            check("rd_error", 32'(rd_error_o), 32'(err_exp));
        end
    end

    // Write-side monitor: wr_error_o pulses exactly after an attempt made while full.
    initial begin
        logic err_exp;
        forever begin
            @(posedge wr_clk_i);
            err_exp = wr_en_i && full_o && !rst_i;
            #1;
            check("wr_error", 32'(wr_error_o), 32'(err_exp));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wr_word(input logic [7:0] d, input bit push);
        @(negedge wr_clk_i);
        wr_en_i = 1'b1;
        wdata_i = d;
        if (push) sb.push_back(d);
    endtask

    task automatic wr_idle();
        @(negedge wr_clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic rd_word();
        @(negedge rd_clk_i);
        rd_en_i = 1'b1;
    endtask

    task automatic rd_idle();
        @(negedge rd_clk_i);
        rd_en_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge wr_clk_i);
        rst_i = 1'b1;
        #1;
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full",  32'(full_o),  32'd0);
        check("rst_rdata", 32'(rdata_o), 32'd0);
        sb.delete();
        repeat (2) @(negedge wr_clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge wr_clk_i);
    endtask

    initial begin
        // Reset state
        #1;
        check("init_empty",    32'(empty_o),    32'd1);
        check("init_full",     32'(full_o),     32'd0);
        check("init_wr_error", 32'(wr_error_o), 32'd0);
        check("init_rd_error", 32'(rd_error_o), 32'd0);
        check("init_rdata",    32'(rdata_o),    32'd0);
        #20;
        rst_i = 1'b0;
        repeat (2) @(negedge wr_clk_i);

        // test_full
        @(posedge wr_clk_i); #1;
        fork
            begin
                for (int i = 0; i < 16; i++) wr_word(8'hA0 + 8'(i), 1'b1);
                @(posedge wr_clk_i); #1;
                check("full_after_16", 32'(full_o), 32'd1);
                wr_idle();
            end
            begin
                int n;
                @(negedge wr_clk_i);
                @(posedge wr_clk_i);
                n = 0;
                while (empty_o && n < 3) begin
                    @(posedge rd_clk_i); #1;
                    n++;
                end
                check("empty_drop_3rd", 32'(empty_o), 32'd0);
            end
        join

        // test_empty
        @(posedge rd_clk_i); #1;
        fork
            begin
                for (int i = 0; i < 16; i++) rd_word();
                @(posedge rd_clk_i); #1;
                check("empty_after_16", 32'(empty_o), 32'd1);
                check("last_word_16",   32'(rdata_o), 32'hAF);
                rd_idle();
            end
            begin
                int n;
                @(negedge rd_clk_i);
                @(posedge rd_clk_i);
                n = 0;
                while (full_o && n < 3) begin
                    @(posedge wr_clk_i); #1;
                    n++;
                end
                check("full_clear_3wr", 32'(full_o), 32'd0);
            end
        join
        check("sb_after_empty", 32'(sb.size()), 32'd0);

        // test_full_error
        do_reset();
        @(posedge wr_clk_i); #1;
        for (int i = 0; i < 16; i++) wr_word(8'h50 + 8'(i * 3), 1'b1);
        @(posedge wr_clk_i); #1;
        check("ferr_full_16", 32'(full_o), 32'd1);
        wr_word(8'hEE, 1'b0);
        @(posedge wr_clk_i); #1;
        check("ferr_pulse",   32'(wr_error_o), 32'd1);
        check("ferr_full_17", 32'(full_o),     32'd1);
        wr_idle();
        @(posedge wr_clk_i); #1;
        check("ferr_pulse_end", 32'(wr_error_o), 32'd0);

        // test_empty_error
        @(posedge rd_clk_i); #1;
        for (int i = 0; i < 17; i++) rd_word();
        @(posedge rd_clk_i); #1;
        check("eerr_pulse", 32'(rd_error_o), 32'd1);
        check("eerr_rdata", 32'(rdata_o),    32'h7D);
        check("eerr_empty", 32'(empty_o),    32'd1);
        rd_idle();
        @(posedge rd_clk_i); #1;
        check("eerr_pulse_end", 32'(rd_error_o), 32'd0);
        check("eerr_rdata_hold", 32'(rdata_o),   32'h7D);
        check("eerr_sb_drained", 32'(sb.size()), 32'd0);

        // test_concurrent_wr_rd
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    repeat ($urandom_range(1, 10)) @(posedge wr_clk_i);
                    wr_word(8'hC0 + 8'(i), 1'b1);
                    wr_idle();
                end
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    int tries;
                    repeat ($urandom_range(1, 10)) @(posedge rd_clk_i);
                    @(negedge rd_clk_i);
                    tries = 0;
                    while (empty_o && tries < 200) begin
                        @(negedge rd_clk_i);
                        tries++;
                    end
                    check("conc_rd_wait", 32'(tries < 200), 32'd1);
                    rd_en_i = 1'b1;
                    rd_idle();
                end
            end
        join
        repeat (4) @(posedge rd_clk_i); #1;
        check("conc_sb_drained", 32'(sb.size()), 32'd0);
        check("conc_empty",      32'(empty_o),   32'd1);
        check("conc_last",       32'(rdata_o),   32'hC9);

        // Reset mid-stream with 5 words stored
        do_reset();
        for (int i = 0; i < 7; i++) wr_word(8'h30 + 8'(i), 1'b1);
        wr_idle();
        repeat (4) @(posedge rd_clk_i); #1;
        rd_word();
        rd_word();
        rd_idle();
        @(posedge rd_clk_i); #1;
        check("mid_rdata_before", 32'(rdata_o), 32'h31);
        check("mid_sb_5",         32'(sb.size()), 32'd5);
        do_reset();
        wr_word(8'hA5, 1'b1);
        wr_idle();
        repeat (4) @(posedge rd_clk_i); #1;
        check("mid_not_empty", 32'(empty_o), 32'd0);
        rd_word();
        rd_idle();
        @(posedge rd_clk_i); #1;
        check("mid_new_word", 32'(rdata_o), 32'hA5);
        check("mid_empty",    32'(empty_o), 32'd1);
        check("mid_sb_final", 32'(sb.size()), 32'd0);

        repeat (3) @(posedge wr_clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
